// File: rtl/smem_pkg.sv
// Shared constants and types for the per-core shared-memory request sequencer.
package smem_pkg;

  localparam int unsigned N_CORES = 16;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BANK_W  = 4;
  localparam int unsigned OFFS_W  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } slot_state_e;

  // Bank field in the upper nibble; the bank arbiters decode it, not this block.
  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [OFFS_W-1:0] offs;
  } smem_addr_t;

endpackage

// File: rtl/smem_req_controller_if.sv
// Core-side request/response and bank-arbiter-side bus bundle for smem_req_controller.
interface smem_req_controller_if;
  import smem_pkg::*;

  logic [N_CORES-1:0]        req_valid;
  logic [N_CORES-1:0]        req_write;
  logic [N_CORES*ADDR_W-1:0] req_addr;
  logic [N_CORES*DATA_W-1:0] req_wdata;
  logic [N_CORES-1:0]        req_ready;
  logic [N_CORES-1:0]        rsp_valid;
  logic [N_CORES*DATA_W-1:0] rsp_rdata;
  logic [N_CORES-1:0]        rsp_err;
  logic [N_CORES-1:0]        read;
  logic [N_CORES-1:0]        write;
  logic [N_CORES*ADDR_W-1:0] addr_out;
  logic [N_CORES*DATA_W-1:0] data_out;
  logic [N_CORES-1:0]        arb_finish;
  logic [N_CORES*DATA_W-1:0] arb_rdata;

  // Controller view.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, arb_finish, arb_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, read, write, addr_out, data_out
  );

  // Cores plus bank arbiters view.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, arb_finish, arb_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, read, write, addr_out, data_out
  );

endinterface

// File: rtl/smem_req_slot.sv
// One core's request slot: IDLE/ISSUE/RESP sequencer with capture registers.
// Optional watchdog enabled by defining SMEM_TIMEOUT_EN.
module smem_req_slot
  import smem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              arb_finish_i,
  input  logic [DATA_W-1:0] arb_rdata_i
);

  slot_state_e       state_q;
  logic              wr_q;
  logic              ready_q;
  logic              rsp_valid_q;
  smem_addr_t        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef SMEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  logic       expire;

  // Fires at the end of the TIMEOUT-th ISSUE cycle.
  assign expire = (cnt_q == 8'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
`ifdef SMEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            state_q <= StIssue;
            ready_q <= 1'b0;
            wr_q    <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
`ifdef SMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StIssue: begin
          if (arb_finish_i) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rdata_q     <= wr_q ? '0 : arb_rdata_i;
`ifdef SMEM_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (expire) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 1'b1;
          end else begin
            cnt_q       <= cnt_q + 8'd1;
`endif
          end
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  // Dropping the strobe in the finish cycle keeps the arbiter from serving us twice.
  assign read_o      = (state_q == StIssue) & ~wr_q & ~arb_finish_i;
  assign write_o     = (state_q == StIssue) &  wr_q & ~arb_finish_i;
  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign addr_o      = addr_q;
  assign data_o      = wdata_q;

`ifdef SMEM_TIMEOUT_EN
  assign rsp_err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign rsp_err_o      = 1'b0;
`endif

endmodule

// File: rtl/smem_req_controller.sv
// Sixteen independent request slots between the cores and the broadcast bank-arbiter buses.
// Watchdog per slot is built only when SMEM_TIMEOUT_EN is defined.
module smem_req_controller
  import smem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  smem_req_controller_if.slave  bus
);

  logic [N_CORES-1:0]        ready_v;
  logic [N_CORES-1:0]        rsp_valid_v;
  logic [N_CORES*DATA_W-1:0] rsp_rdata_v;
  logic [N_CORES-1:0]        rsp_err_v;
  logic [N_CORES-1:0]        read_v;
  logic [N_CORES-1:0]        write_v;
  logic [N_CORES*ADDR_W-1:0] addr_v;
  logic [N_CORES*DATA_W-1:0] data_v;

  for (genvar i = 0; i < N_CORES; i++) begin : g_slot
    smem_req_slot #(
      .TIMEOUT (TIMEOUT)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (bus.req_valid[i]),
      .req_write_i  (bus.req_write[i]),
      .req_addr_i   (bus.req_addr[ADDR_W*i +: ADDR_W]),
      .req_wdata_i  (bus.req_wdata[DATA_W*i +: DATA_W]),
      .req_ready_o  (ready_v[i]),
      .rsp_valid_o  (rsp_valid_v[i]),
      .rsp_rdata_o  (rsp_rdata_v[DATA_W*i +: DATA_W]),
      .rsp_err_o    (rsp_err_v[i]),
      .read_o       (read_v[i]),
      .write_o      (write_v[i]),
      .addr_o       (addr_v[ADDR_W*i +: ADDR_W]),
      .data_o       (data_v[DATA_W*i +: DATA_W]),
      .arb_finish_i (bus.arb_finish[i]),
      .arb_rdata_i  (bus.arb_rdata[DATA_W*i +: DATA_W])
    );
  end

  assign bus.req_ready = ready_v;
  assign bus.rsp_valid = rsp_valid_v;
  assign bus.rsp_rdata = rsp_rdata_v;
  assign bus.rsp_err   = rsp_err_v;
  assign bus.read      = read_v;
  assign bus.write     = write_v;
  assign bus.addr_out  = addr_v;
  assign bus.data_out  = data_v;

endmodule

// File: tb/tb_smem_req_controller.sv
// Self-checking bench for smem_req_controller: directed scenarios plus a randomized
// run against a transaction-level model with a shared memory playing the bank arbiters.
module tb_smem_req_controller;
  import smem_pkg::*;

  localparam int unsigned TO = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  smem_req_controller_if bus ();

  smem_req_controller #(
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish got running want finished");
    $fatal(1, "bench timeout");
  end

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.arb_finish = '0;
    bus.arb_rdata  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    n_tests++; if (bus.req_ready !== 16'hFFFF) begin n_fail++;
      $display("FAIL reset_ready got %h want ffff", bus.req_ready); end
    n_tests++; if ({bus.rsp_valid, bus.rsp_err, bus.read, bus.write} !== 64'h0) begin n_fail++;
      $display("FAIL reset_flags got %h/%h/%h/%h want 0", bus.rsp_valid, bus.rsp_err,
               bus.read, bus.write); end
    n_tests++; if ({bus.rsp_rdata, bus.addr_out, bus.data_out} !== '0) begin n_fail++;
      $display("FAIL reset_data got %h/%h/%h want 0", bus.rsp_rdata, bus.addr_out,
               bus.data_out); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_core0();
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b1;
    bus.req_addr[11:0] = 12'h312; bus.req_wdata[7:0] = 8'hA5;
    #1;
    n_tests++; if (bus.req_ready[0] !== 1'b1) begin n_fail++;
      $display("FAIL wr0_idle_ready got %b want 1", bus.req_ready[0]); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; bus.req_valid[0] = 1'b0; #1;
      n_tests++;
      if ({bus.write[0], bus.read[0], bus.req_ready[0]} !== 3'b100) begin n_fail++;
        $display("FAIL wr0_issue%0d got w/r/rdy %b%b%b want 100", k, bus.write[0],
                 bus.read[0], bus.req_ready[0]); end
    end
    @(posedge clk); #1;
    bus.arb_finish[0] = 1'b1; bus.arb_rdata[7:0] = 8'h77; #1;
    n_tests++; if (bus.write[0] !== 1'b0) begin n_fail++;
      $display("FAIL wr0_finish_gate got %b want 0", bus.write[0]); end
    n_tests++; if ({bus.addr_out[11:0], bus.data_out[7:0]} !== {12'h312, 8'hA5}) begin n_fail++;
      $display("FAIL wr0_bus got %h/%h want 312/a5", bus.addr_out[11:0], bus.data_out[7:0]); end
    @(posedge clk); #1;
    bus.arb_finish[0] = 1'b0; bus.arb_rdata[7:0] = 8'h00; #1;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_rdata[7:0], bus.rsp_err[0], bus.req_ready[0]} !==
        {16'h0001, 8'h00, 1'b0, 1'b0}) begin n_fail++;
      $display("FAIL wr0_rsp got v=%h d=%h e=%b rdy=%b want 0001/00/0/0", bus.rsp_valid,
               bus.rsp_rdata[7:0], bus.rsp_err[0], bus.req_ready[0]); end
    @(posedge clk); #2;
    n_tests++; if ({bus.rsp_valid, bus.req_ready[0], bus.write[0]} !== {16'h0, 2'b10}) begin
      n_fail++;
      $display("FAIL wr0_done got v=%h rdy=%b w=%b want 0000/1/0", bus.rsp_valid,
               bus.req_ready[0], bus.write[0]); end
  endtask

  task automatic test_read_core5();
    @(posedge clk); #1;
    bus.req_valid[5] = 1'b1; bus.req_write[5] = 1'b0; bus.req_addr[71:60] = 12'h312;
    @(posedge clk); #1; bus.req_valid[5] = 1'b0; #1;
    n_tests++; if ({bus.read[5], bus.write[5]} !== 2'b10) begin n_fail++;
      $display("FAIL rd5_issue got r/w %b%b want 10", bus.read[5], bus.write[5]); end
    @(posedge clk); #1;
    bus.arb_finish[5] = 1'b1; bus.arb_rdata[47:40] = 8'hA5; #1;
    n_tests++; if (bus.read[5] !== 1'b0) begin n_fail++;
      $display("FAIL rd5_finish_gate got %b want 0", bus.read[5]); end
    @(posedge clk); #1;
    bus.arb_finish[5] = 1'b0; bus.arb_rdata[47:40] = 8'h00; #1;
    n_tests++; if ({bus.rsp_valid, bus.rsp_rdata[47:40]} !== {16'h0020, 8'hA5}) begin n_fail++;
      $display("FAIL rd5_rsp got v=%h d=%h want 0020/a5", bus.rsp_valid, bus.rsp_rdata[47:40]);
    end
    @(posedge clk); #2;
    n_tests++; if (bus.rsp_valid !== 16'h0) begin n_fail++;
      $display("FAIL rd5_single got %h want 0000", bus.rsp_valid); end
  endtask

  task automatic test_all16();
    logic [15:0]  wv, pend, fin, exp_rsp, cnt_ok;
    logic [191:0] av;
    logic [127:0] dv, rdv, exp_rd;
    int           cnt [16];
    wv = 16'($urandom) | 16'h0101;
    wv = wv & 16'hBFFD;
    for (int i = 0; i < 16; i++) begin
      av[12*i +: 12]  = 12'($urandom);
      dv[8*i +: 8]    = 8'($urandom);
      rdv[8*i +: 8]   = 8'(i * 17 + 3);
      exp_rd[8*i +: 8] = wv[i] ? 8'h00 : 8'(i * 17 + 3);
      cnt[i] = 0;
    end
    @(posedge clk); #1;
    bus.req_valid = 16'hFFFF; bus.req_write = wv; bus.req_addr = av; bus.req_wdata = dv;
    @(posedge clk); #1; bus.req_valid = '0; #1;
    n_tests++; if ({bus.read, bus.write} !== {~wv, wv}) begin n_fail++;
      $display("FAIL all16_strobes got r=%h w=%h want r=%h w=%h", bus.read, bus.write, ~wv, wv);
    end
    n_tests++; if ({bus.addr_out, bus.data_out} !== {av, dv}) begin n_fail++;
      $display("FAIL all16_bus got %h/%h want %h/%h", bus.addr_out, bus.data_out, av, dv); end
    pend = 16'hFFFF;
    exp_rsp = '0;
    for (int k = 0; k < 10; k++) begin
      fin = (k < 8) ? (16'h0003 << (14 - 2 * k)) : 16'h0;
      @(posedge clk); #1;
      bus.arb_finish = fin;
      bus.arb_rdata  = '0;
      for (int i = 0; i < 16; i++) if (fin[i]) bus.arb_rdata[8*i +: 8] = rdv[8*i +: 8];
      #1;
      n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++;
        $display("FAIL all16_rsp%0d got %h want %h", k, bus.rsp_valid, exp_rsp); end
      n_tests++; if (bus.read !== (~wv & pend & ~fin)) begin n_fail++;
        $display("FAIL all16_read%0d got %h want %h", k, bus.read, ~wv & pend & ~fin); end
      for (int i = 0; i < 16; i++) if (bus.rsp_valid[i] === 1'b1) cnt[i]++;
      pend    = pend & ~fin;
      exp_rsp = fin;
    end
    bus.arb_finish = '0; bus.arb_rdata = '0;
    for (int i = 0; i < 16; i++) cnt_ok[i] = (cnt[i] == 1);
    n_tests++; if (cnt_ok !== 16'hFFFF) begin n_fail++;
      $display("FAIL all16_one_rsp got %h want ffff", cnt_ok); end
    n_tests++; if (bus.rsp_rdata !== exp_rd) begin n_fail++;
      $display("FAIL all16_lanes got %h want %h", bus.rsp_rdata, exp_rd); end
    n_tests++; if (bus.req_ready !== 16'hFFFF) begin n_fail++;
      $display("FAIL all16_ready got %h want ffff", bus.req_ready); end
  endtask

  task automatic test_spurious();
    int rsp2;
    @(posedge clk); #1;
    bus.arb_finish[7] = 1'b1; bus.arb_rdata[63:56] = 8'hFF;
    bus.req_valid[2] = 1'b1; bus.req_write[2] = 1'b0; bus.req_addr[35:24] = 12'h1AB;
    @(posedge clk); #1;
    bus.arb_finish[7] = 1'b0; bus.arb_rdata[63:56] = 8'h00;
    bus.req_addr[35:24] = 12'hFFF;
    #1;
    n_tests++; if ({bus.rsp_valid[7], bus.req_ready[7], bus.read[7], bus.write[7]} !== 4'b0100)
    begin n_fail++;
      $display("FAIL spur7 got v/rdy/r/w %b%b%b%b want 0100", bus.rsp_valid[7],
               bus.req_ready[7], bus.read[7], bus.write[7]); end
    rsp2 = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      n_tests++;
      if ({bus.addr_out[35:24], bus.req_ready[2], bus.read[2]} !== {12'h1AB, 2'b01}) begin
        n_fail++;
        $display("FAIL hold2_%0d got a=%h rdy=%b r=%b want 1ab/0/1", k, bus.addr_out[35:24],
                 bus.req_ready[2], bus.read[2]); end
    end
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0; bus.arb_finish[2] = 1'b1; bus.arb_rdata[23:16] = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; bus.arb_finish[2] = 1'b0; bus.arb_rdata[23:16] = 8'h00; #1;
      if (bus.rsp_valid[2] === 1'b1) rsp2++;
    end
    n_tests++; if ({rsp2, bus.rsp_rdata[23:16]} !== {32'd1, 8'h3C}) begin n_fail++;
      $display("FAIL spur2_rsp got n=%0d d=%h want 1/3c", rsp2, bus.rsp_rdata[23:16]); end
    n_tests++; if ({bus.req_ready[2], bus.read[2]} !== 2'b10) begin n_fail++;
      $display("FAIL spur2_idle got rdy/r %b%b want 10", bus.req_ready[2], bus.read[2]); end
  endtask

  task automatic test_random();
    logic [7:0]  mem [4096];
    bit          busy [16];
    bit          w [16];
    int          age [16], lat [16];
    logic [11:0] a [16], last_a [16], na [16];
    logic [7:0]  d [16], last_d [16], nd [16], exp_rd [16];
    bit          nv [16], nw [16];
    logic [15:0] e_rdy, e_rsp, e_rd, e_wr;
    logic [191:0] e_addr;
    logic [127:0] e_data;
    for (int j = 0; j < 4096; j++) mem[j] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      busy[i] = 0; age[i] = 0; lat[i] = 0; last_a[i] = '0; last_d[i] = '0; exp_rd[i] = '0;
    end
    rst_n = 1'b0; clear_inputs();
    @(posedge clk); @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
        nv[i] = 0;
        bus.req_valid[i] = 1'b0; bus.arb_finish[i] = 1'b0; bus.arb_rdata[8*i +: 8] = '0;
        if (busy[i] && age[i] == lat[i]) begin
          bus.arb_finish[i] = 1'b1;
          if (w[i]) begin mem[a[i]] = d[i]; exp_rd[i] = '0; end
          else begin bus.arb_rdata[8*i +: 8] = mem[a[i]]; exp_rd[i] = mem[a[i]]; end
        end else if (!busy[i] && c < 400 && $urandom_range(0, 2) == 0) begin
          nv[i] = 1; nw[i] = 1'($urandom); na[i] = 12'($urandom); nd[i] = 8'($urandom);
          bus.req_valid[i] = 1'b1; bus.req_write[i] = nw[i];
          bus.req_addr[12*i +: 12] = na[i]; bus.req_wdata[8*i +: 8] = nd[i];
        end else if ($urandom_range(0, 7) == 0 && !(busy[i] && age[i] < lat[i])) begin
          bus.arb_finish[i] = 1'b1; bus.arb_rdata[8*i +: 8] = 8'($urandom);
        end
      end
      #1;
      for (int i = 0; i < 16; i++) begin
        e_rdy[i] = !busy[i];
        e_rsp[i] = busy[i] && age[i] == lat[i] + 1;
        e_rd[i]  = busy[i] && age[i] < lat[i] && !w[i];
        e_wr[i]  = busy[i] && age[i] < lat[i] && w[i];
        e_addr[12*i +: 12] = last_a[i];
        e_data[8*i +: 8]   = last_d[i];
      end
      n_tests++; if ({bus.req_ready, bus.rsp_valid} !== {e_rdy, e_rsp}) begin n_fail++;
        $display("FAIL rnd_hs c=%0d got rdy=%h v=%h want rdy=%h v=%h", c, bus.req_ready,
                 bus.rsp_valid, e_rdy, e_rsp); end
      n_tests++; if ({bus.read, bus.write} !== {e_rd, e_wr}) begin n_fail++;
        $display("FAIL rnd_strobe c=%0d got r=%h w=%h want r=%h w=%h", c, bus.read, bus.write,
                 e_rd, e_wr); end
      n_tests++; if ({bus.addr_out, bus.data_out} !== {e_addr, e_data}) begin n_fail++;
        $display("FAIL rnd_bus c=%0d got %h/%h want %h/%h", c, bus.addr_out, bus.data_out,
                 e_addr, e_data); end
      for (int i = 0; i < 16; i++) begin
        if (e_rsp[i]) begin
          n_tests++;
          if ({bus.rsp_rdata[8*i +: 8], bus.rsp_err[i]} !== {exp_rd[i], 1'b0}) begin n_fail++;
            $display("FAIL rnd_rdata c=%0d core=%0d got %h/%b want %h/0", c, i,
                     bus.rsp_rdata[8*i +: 8], bus.rsp_err[i], exp_rd[i]); end
        end
        if (busy[i]) begin
          age[i]++;
          if (age[i] > lat[i] + 1) busy[i] = 0;
        end else if (nv[i]) begin
          busy[i] = 1; age[i] = 1; lat[i] = $urandom_range(1, 6);
          w[i] = nw[i]; a[i] = na[i]; d[i] = nd[i]; last_a[i] = na[i]; last_d[i] = nd[i];
        end
      end
    end
    clear_inputs();
  endtask

`ifdef SMEM_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      bus.req_valid[9] = 1'b1; bus.req_write[9] = 1'b0; bus.req_addr[119:108] = 12'h9AB;
      for (int k = 1; k <= int'(TO); k++) begin
        @(posedge clk); #1;
        bus.req_valid[9] = 1'b0;
        if (pass == 0 && k == int'(TO)) begin
          bus.arb_finish[9] = 1'b1; bus.arb_rdata[79:72] = 8'h5A;
        end
        #1;
        n_tests++; if (bus.rsp_valid[9] !== 1'b0) begin n_fail++;
          $display("FAIL to_early p=%0d k=%0d got %b want 0", pass, k, bus.rsp_valid[9]); end
      end
      @(posedge clk); #1; bus.arb_finish[9] = 1'b0; bus.arb_rdata[79:72] = 8'h00; #1;
      n_tests++;
      if ({bus.rsp_valid[9], bus.rsp_err[9], bus.rsp_rdata[79:72]} !==
          ((pass == 0) ? {2'b10, 8'h5A} : {2'b11, 8'h00})) begin n_fail++;
        $display("FAIL to_rsp p=%0d got v=%b e=%b d=%h want %s", pass, bus.rsp_valid[9],
                 bus.rsp_err[9], bus.rsp_rdata[79:72], (pass == 0) ? "1/0/5a" : "1/1/00"); end
      @(posedge clk); #2;
      n_tests++; if ({bus.rsp_valid[9], bus.req_ready[9]} !== 2'b01) begin n_fail++;
        $display("FAIL to_done p=%0d got v/rdy %b%b want 01", pass, bus.rsp_valid[9],
                 bus.req_ready[9]); end
    end
  endtask
`endif

  task automatic test_reset_mid_issue();
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b1; bus.req_write[3] = 1'b0; bus.req_addr[47:36] = 12'h456;
    @(posedge clk); #1; bus.req_valid[3] = 1'b0; #1;
    n_tests++; if (bus.read[3] !== 1'b1) begin n_fail++;
      $display("FAIL rst3_issue got %b want 1", bus.read[3]); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.read[3], bus.req_ready, bus.rsp_valid} !== {1'b0, 16'hFFFF, 16'h0})
    begin n_fail++;
      $display("FAIL rst3_async got r=%b rdy=%h v=%h want 0/ffff/0000", bus.read[3],
               bus.req_ready, bus.rsp_valid); end
    n_tests++; if (bus.addr_out !== '0) begin n_fail++;
      $display("FAIL rst3_addr got %h want 0", bus.addr_out); end
    @(posedge clk); @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; bus.arb_finish[3] = (k == 0); #1;
      n_tests++; if ({bus.rsp_valid, bus.read} !== 32'h0) begin n_fail++;
        $display("FAIL rst3_norsp%0d got v=%h r=%h want 0/0", k, bus.rsp_valid, bus.read); end
    end
    bus.arb_finish[3] = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write_core0();
    test_read_core5();
    test_all16();
    test_spurious();
    test_random();
`ifdef SMEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
